// File: rtl/lr2_seq_ctrl.sv
// Sequences an external up/down counter from START to END for REPS+1 passes; one LOAD cycle per pass.
// Latency: steps+2 cycles per pass, DONE one cycle after the last pass; cmd_ready only in IDLE.
module lr2_seq_ctrl #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [W-1:0] cmd_start,
    input  logic [W-1:0] cmd_end,
    input  logic         cmd_up,
    input  logic [3:0]   cmd_reps,
    input  logic         abort,
    input  logic [W-1:0] cnt_seq,
    output logic         cnt_ce,
    output logic         cnt_load,
    output logic [W-1:0] cnt_dat,
    output logic         cnt_up,
    output logic         busy,
    output logic         done,
    output logic [3:0]   pass_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    state_t         state;
    logic [W-1:0]   start_q;
    logic [W-1:0]   end_q;
    logic           up_q;
    logic [3:0]     reps_q;
    logic           at_end;

    assign at_end = (cnt_seq == end_q);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            start_q  <= '0;
            end_q    <= '0;
            up_q     <= 1'b0;
            reps_q   <= 4'd0;
            pass_cnt <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid && !abort) begin
                        start_q  <= cmd_start;
                        end_q    <= cmd_end;
                        up_q     <= cmd_up;
                        reps_q   <= cmd_reps;
                        pass_cnt <= 4'd0;
                        state    <= S_LOAD;
                    end
                end
                S_LOAD: state <= abort ? S_IDLE : S_RUN;
                S_RUN: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (at_end) begin
                        // pass_cnt still holds completed passes before this one
                        pass_cnt <= pass_cnt + 4'd1;
                        state    <= (pass_cnt == reps_q) ? S_DONE : S_LOAD;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Every output is forced low while rst is held, independent of the registered state.
    assign cmd_ready = rst && (state == S_IDLE) && !abort;
    assign cnt_load  = rst && (state == S_LOAD) && !abort;
    assign cnt_ce    = rst && (state == S_RUN) && !abort && !at_end;
    assign cnt_dat   = rst ? start_q : '0;
    assign cnt_up    = rst && up_q;
    assign busy      = rst && ((state == S_LOAD) || (state == S_RUN));
    assign done      = rst && (state == S_DONE);

endmodule
